// File: rtl/uart_rx_axis_if.sv
// Byte stream from the UART receiver to core logic.
// Plain valid/ready handshake: the source holds tdata stable while tvalid is high.
interface uart_rx_axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver with 8x oversampling under a runtime prescale, feeding an AXI-stream byte.
// Latency: tvalid rises 1 clk after the mid-stop-bit sample (T+76P+1 from the synchronized start edge).
// Backpressure: single output register; a new byte overwrites an unconsumed one and pulses overrun_error.
module uart_rx_axis #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic [PRESCALE_W-1:0] prescale,
    uart_rx_axis_if.master        m_axis,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error
);
    localparam int CNT_W = PRESCALE_W + 3;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                  rxd_meta;
    logic                  rxd_sync;
    logic                  rxd_prev;
    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [PRESCALE_W-1:0] p_reg;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;

    logic [PRESCALE_W-1:0] p_new;
    logic [CNT_W-1:0]      half_load;
    logic [CNT_W-1:0]      bit_load;
    logic                  expired;

    // Zero prescale would stall the counter forever; run it as the fastest rate instead.
    assign p_new     = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    assign half_load = {1'b0, p_new, 2'b00} - CNT_W'(1);
    assign bit_load  = {p_reg, 3'b000} - CNT_W'(1);
    assign expired   = (cnt == '0);

    assign busy          = (state != S_IDLE);
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            p_reg         <= '0;
            shreg         <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    // Edge-triggered start: a line stuck low never re-arms until it goes high.
                    if (rxd_prev && !rxd_sync) begin
                        p_reg <= p_new;
                        cnt   <= half_load;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (!expired) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!rxd_sync) begin
                        cnt     <= bit_load;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!expired) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        shreg   <= {rxd_sync, shreg[DATA_WIDTH-1:1]};
                        cnt     <= bit_load;
                        bit_idx <= bit_idx + BIT_W'(1);
                        if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (!expired) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= S_IDLE;
                        if (rxd_sync) begin
                            // A byte taken in this same cycle frees the register, so that is not an overrun.
                            tdata_q       <= shreg;
                            tvalid_q      <= 1'b1;
                            overrun_error <= tvalid_q && !m_axis.tready;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: serial frames in, byte handshakes and error pulses checked against hand-derived cycles.
module tb_uart_rx_axis;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd;
    logic [15:0] prescale;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;

    uart_rx_axis_if #(.DATA_WIDTH(8)) axis ();

    uart_rx_axis #(.DATA_WIDTH(8), .PRESCALE_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .prescale      (prescale),
        .m_axis        (axis.master),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] acc_dat[$];
    int         acc_cyc[$];
    int         ferr_cyc[$];
    int         ovr_cyc[$];
    int         brise[$];
    int         bfall[$];
    logic       busy_d = 1'b0;

    // Event log sampled mid-cycle; cyc is the index of the last rising edge.
    always @(negedge clk) begin
        if (axis.tvalid && axis.tready) begin
            acc_dat.push_back(axis.tdata);
            acc_cyc.push_back(cyc);
        end
        if (frame_error)   ferr_cyc.push_back(cyc);
        if (overrun_error) ovr_cyc.push_back(cyc);
        if (busy && !busy_d) brise.push_back(cyc);
        if (!busy && busy_d) bfall.push_back(cyc);
        busy_d = busy;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log;
        acc_dat.delete(); acc_cyc.delete(); ferr_cyc.delete();
        ovr_cyc.delete(); brise.delete(); bfall.delete();
    endtask

    // Drives one frame at 8*p clk per bit; c0 is the cycle the start bit is driven.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p, output int c0);
        c0 = cyc;
        rxd = 1'b0;
        repeat (8 * p) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (8 * p) tick();
        end
        rxd = stop;
        repeat (8 * p) tick();
    endtask

    task automatic test_reset;
        repeat (3) tick();
        checks++; if (axis.tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h exp 00", axis.tdata); end
        checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", axis.tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun_error); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_error); end
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_nominal;
        int c0;
        logic [7:0] d;
        prescale = 16'd1;
        axis.tready = 1'b1;
        clear_log();
        send_frame(8'h55, 1'b1, 1, c0);
        repeat (4) tick();
        d = (acc_dat.size() > 0) ? acc_dat[0] : 8'hEE;
        checks++; if (acc_dat.size() !== 1) begin errors++; $display("FAIL nom_count got %0d exp 1", acc_dat.size()); end
        checks++; if (d !== 8'h55) begin errors++; $display("FAIL nom_data got %h exp 55", d); end
        checks++; if (acc_cyc.size() == 0 || acc_cyc[0] !== c0 + 79) begin errors++; $display("FAIL nom_valid_cycle got %0d exp %0d", acc_cyc.size() ? acc_cyc[0] - c0 : -1, 79); end
        checks++; if (brise.size() == 0 || brise[0] !== c0 + 3) begin errors++; $display("FAIL nom_busy_rise got %0d exp %0d", brise.size() ? brise[0] - c0 : -1, 3); end
        checks++; if (bfall.size() == 0 || bfall[0] !== c0 + 79) begin errors++; $display("FAIL nom_busy_fall got %0d exp %0d", bfall.size() ? bfall[0] - c0 : -1, 79); end
        checks++; if (ferr_cyc.size() + ovr_cyc.size() !== 0) begin errors++; $display("FAIL nom_errors got %0d exp 0", ferr_cyc.size() + ovr_cyc.size()); end
    endtask

    task automatic test_glitch;
        int c0;
        prescale = 16'd4;
        clear_log();
        c0 = cyc;
        rxd = 1'b0;
        repeat (2) tick();
        rxd = 1'b1;
        repeat (60) tick();
        checks++; if (brise.size() == 0 || brise[0] !== c0 + 3) begin errors++; $display("FAIL glitch_busy_rise got %0d exp %0d", brise.size() ? brise[0] - c0 : -1, 3); end
        checks++; if (bfall.size() == 0 || bfall[0] !== c0 + 19) begin errors++; $display("FAIL glitch_busy_fall got %0d exp %0d", bfall.size() ? bfall[0] - c0 : -1, 19); end
        checks++; if (acc_dat.size() !== 0 || axis.tvalid !== 1'b0) begin errors++; $display("FAIL glitch_output got %0d/%b exp 0/0", acc_dat.size(), axis.tvalid); end
        checks++; if (ferr_cyc.size() + ovr_cyc.size() !== 0) begin errors++; $display("FAIL glitch_errors got %0d exp 0", ferr_cyc.size() + ovr_cyc.size()); end
    endtask

    task automatic test_framing;
        int c0;
        prescale = 16'd1;
        clear_log();
        send_frame(8'hA3, 1'b0, 1, c0);
        repeat (100) tick();
        checks++; if (ferr_cyc.size() !== 1) begin errors++; $display("FAIL frm_err_count got %0d exp 1", ferr_cyc.size()); end
        checks++; if (ferr_cyc.size() == 0 || ferr_cyc[0] !== c0 + 79) begin errors++; $display("FAIL frm_err_cycle got %0d exp %0d", ferr_cyc.size() ? ferr_cyc[0] - c0 : -1, 79); end
        checks++; if (acc_dat.size() !== 0 || axis.tvalid !== 1'b0) begin errors++; $display("FAIL frm_tvalid got %0d/%b exp 0/0", acc_dat.size(), axis.tvalid); end
        checks++; if (axis.tdata !== 8'h55) begin errors++; $display("FAIL frm_tdata_kept got %h exp 55", axis.tdata); end
        checks++; if (brise.size() !== 1 || busy !== 1'b0) begin errors++; $display("FAIL frm_break_restart got %0d/%b exp 1/0", brise.size(), busy); end
        rxd = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_overrun;
        int c1;
        int c2;
        prescale = 16'd1;
        axis.tready = 1'b0;
        clear_log();
        send_frame(8'h12, 1'b1, 1, c1);
        checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h12) begin errors++; $display("FAIL ovr_first got %b/%h exp 1/12", axis.tvalid, axis.tdata); end
        send_frame(8'h34, 1'b1, 1, c2);
        repeat (5) tick();
        checks++; if (ovr_cyc.size() !== 1) begin errors++; $display("FAIL ovr_count got %0d exp 1", ovr_cyc.size()); end
        checks++; if (ovr_cyc.size() == 0 || ovr_cyc[0] !== c2 + 79) begin errors++; $display("FAIL ovr_cycle got %0d exp %0d", ovr_cyc.size() ? ovr_cyc[0] - c2 : -1, 79); end
        checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h34) begin errors++; $display("FAIL ovr_hold got %b/%h exp 1/34", axis.tvalid, axis.tdata); end
        axis.tready = 1'b1;
        repeat (3) tick();
        checks++; if (acc_dat.size() !== 1 || acc_dat[0] !== 8'h34 || axis.tvalid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %0d/%b exp 1/0", acc_dat.size(), axis.tvalid); end
    endtask

    task automatic test_back_to_back;
        int c0;
        int cx;
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h80;
        prescale = 16'd2;
        axis.tready = 1'b1;
        clear_log();
        send_frame(exp_b[0], 1'b1, 2, c0);
        send_frame(exp_b[1], 1'b1, 2, cx);
        send_frame(exp_b[2], 1'b1, 2, cx);
        repeat (10) tick();
        checks++; if (acc_dat.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", acc_dat.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_dat.size() <= i || acc_dat[i] !== exp_b[i] || acc_cyc[i] !== c0 + 155 + 160 * i) begin
                errors++;
                $display("FAIL b2b_byte%0d got %h@%0d exp %h@%0d", i, acc_dat.size() > i ? acc_dat[i] : 8'hEE,
                         acc_cyc.size() > i ? acc_cyc[i] - c0 : -1, exp_b[i], 155 + 160 * i);
            end
        end
        checks++; if (ferr_cyc.size() + ovr_cyc.size() !== 0) begin errors++; $display("FAIL b2b_errors got %0d exp 0", ferr_cyc.size() + ovr_cyc.size()); end
    endtask

    task automatic test_reset_midframe;
        int c0;
        prescale = 16'd1;
        axis.tready = 1'b1;
        clear_log();
        c0 = cyc;
        rxd = 1'b0;
        repeat (8) tick();
        rxd = 1'b1;
        repeat (8) tick();
        rxd = 1'b0;
        repeat (16) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
        rst_n = 1'b0;
        rxd = 1'b1;
        #1;
        checks++; if (axis.tdata !== 8'h00 || axis.tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got %h/%b/%b exp 00/0/0", axis.tdata, axis.tvalid, busy); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++; if (acc_dat.size() + ferr_cyc.size() + ovr_cyc.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_aborted got %0d/%b exp 0/0", acc_dat.size() + ferr_cyc.size(), busy); end
        clear_log();
        send_frame(8'hC3, 1'b1, 1, c0);
        repeat (4) tick();
        checks++; if (acc_dat.size() !== 1 || acc_dat[0] !== 8'hC3 || acc_cyc[0] !== c0 + 79) begin errors++; $display("FAIL rstmid_next got %0d/%h exp 1/c3", acc_dat.size(), acc_dat.size() ? acc_dat[0] : 8'hEE); end
    endtask

    initial begin
        rst_n = 1'b0;
        rxd = 1'b1;
        prescale = 16'd1;
        axis.tready = 1'b0;
        test_reset();
        test_nominal();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
